// File: rtl/rx_symbol_lock_ctrl.sv
// -----------------------------------------------------------------------------
// rx_symbol_lock_ctrl
//
// Rx-lane controller that sits between the deserialiser and the 10b->8b
// decoder. It hunts for a K28.5 comma in a 20-bit sliding window built from
// the previous and the current raw word, confirms the boundary with a run of
// commas at the same offset, then feeds aligned symbols to the decoder and
// watches its error flag to decide when lock has been lost.
//
// Ports:
//   clk             clock
//   rst             asynchronous reset, active low
//   rx_raw_i        raw deserialised word (arbitrary bit slip)
//   rx_raw_valid_i  rx_raw_i valid this cycle
//   dec_err_i       decoder error, valid one cycle after dec_en_o
//   dec_rd_next_i   decoder running-disparity output
//   sym_out_o       aligned symbol to decoder data input
//   dec_en_o        decoder enable
//   dec_rd_prev_o   running disparity fed to the decoder
//   lock_o          symbol lock achieved
//   align_off_o     selected bit offset 0..9
//   err_count_o     saturating total decode-error count
//
// Build option:
//   RX_LOCK_ERR_STATS_EN  when defined, err_count_o counts every sampled
//                         decoder error (saturating at 255, cleared only by
//                         reset); when undefined err_count_o is tied to 0.
// -----------------------------------------------------------------------------
module rx_symbol_lock_ctrl #(
   parameter int COMMA_LOCK_CNT = 4,
   parameter int ERR_LIMIT      = 4,
   parameter int GOOD_RUN       = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] rx_raw_i,
   input  logic       rx_raw_valid_i,
   input  logic       dec_err_i,
   input  logic       dec_rd_next_i,
   output logic [9:0] sym_out_o,
   output logic       dec_en_o,
   output logic       dec_rd_prev_o,
   output logic       lock_o,
   output logic [3:0] align_off_o,
   output logic [7:0] err_count_o
);

   localparam logic [3:0] LOCK_CNT_C = 4'(COMMA_LOCK_CNT);
   localparam logic [3:0] ERR_LIM_C  = 4'(ERR_LIMIT);
   localparam logic [7:0] GOOD_RUN_C = 8'(GOOD_RUN);

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   // Upper seven bits of a candidate symbol: RD- or RD+ comma pattern.
   function automatic logic is_comma(input logic [6:0] head);
      return (head == 7'b0011111) || (head == 7'b1100000);
   endfunction

   state_t      state_q, state_d;
   logic [9:0]  prev_q;
   logic        rd_q, rd_d;
   logic [3:0]  align_q, align_d;
   logic [3:0]  comma_cnt_q, comma_cnt_d;
   logic [3:0]  err_cnt_q, err_cnt_d;
   logic [7:0]  good_cnt_q, good_cnt_d;
   logic        dec_vld_q, dec_vld_d;
   logic        dec_en_q, dec_en_d;
   logic [9:0]  sym_q, sym_d;
   logic        lock_q, lock_d;

   // Window is {prev, raw} minus its LSB: no candidate ever starts at bit 0.
   logic [18:0]     win_s;
   logic [9:0][9:0] cand_s;
   logic            any_comma_s;
   logic [3:0]      first_k_s;
   logic            first_pol_s;
   logic            align_comma_s;
   logic            present_s;

   // Candidate extraction and lowest-offset comma search.
   always_comb begin
      win_s         = {prev_q, rx_raw_i[9:1]};
      any_comma_s   = 1'b0;
      first_k_s     = 4'd0;
      first_pol_s   = 1'b0;
      // Scan from the highest offset down so the lowest match overwrites last.
      for (int k = 9; k >= 0; k--) begin
         cand_s[k]   = win_s[18-k -: 10];
         any_comma_s = any_comma_s | is_comma(cand_s[k][9:3]);
         first_k_s   = is_comma(cand_s[k][9:3]) ? 4'(k) : first_k_s;
         first_pol_s = is_comma(cand_s[k][9:3]) ? cand_s[k][9] : first_pol_s;
      end
      align_comma_s = is_comma(cand_s[align_q][9:3]);
   end

   // Lock FSM next state, counters and decoder presentation.
   always_comb begin
      state_d     = state_q;
      align_d     = align_q;
      comma_cnt_d = comma_cnt_q;
      err_cnt_d   = err_cnt_q;
      good_cnt_d  = good_cnt_q;
      // RD chains from the decoder whenever a result comes back.
      rd_d        = dec_vld_q ? dec_rd_next_i : rd_q;

      case (state_q)
         ST_SEARCH: begin
            if (rx_raw_valid_i && any_comma_s) begin
               align_d     = first_k_s;
               comma_cnt_d = 4'd1;
               rd_d        = first_pol_s;
               state_d     = (LOCK_CNT_C == 4'd1) ? ST_LOCKED : ST_CONFIRM;
            end else begin
               state_d = ST_SEARCH;
            end
         end
         ST_CONFIRM: begin
            if (dec_vld_q && dec_err_i) begin
               state_d = ST_SEARCH;
            end else if (rx_raw_valid_i && align_comma_s) begin
               comma_cnt_d = comma_cnt_q + 4'd1;
               state_d     = (comma_cnt_d == LOCK_CNT_C) ? ST_LOCKED : ST_CONFIRM;
            end else if (rx_raw_valid_i && any_comma_s) begin
               // Boundary moved: start counting again at the new offset.
               align_d     = first_k_s;
               comma_cnt_d = 4'd1;
            end else begin
               state_d = ST_CONFIRM;
            end
         end
         ST_LOCKED: begin
            if (dec_vld_q) begin
               if (dec_err_i) begin
                  good_cnt_d = 8'd0;
                  err_cnt_d  = (err_cnt_q >= ERR_LIM_C) ? ERR_LIM_C : err_cnt_q + 4'd1;
               end else if (good_cnt_q + 8'd1 == GOOD_RUN_C) begin
                  good_cnt_d = 8'd0;
                  err_cnt_d  = (err_cnt_q == 4'd0) ? 4'd0 : err_cnt_q - 4'd1;
               end else begin
                  good_cnt_d = good_cnt_q + 8'd1;
               end
               if (err_cnt_d == ERR_LIM_C) begin
                  state_d    = ST_SEARCH;
                  err_cnt_d  = 4'd0;
                  good_cnt_d = 8'd0;
               end else begin
                  state_d = ST_LOCKED;
               end
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_SEARCH;
         end
      endcase

      // Present only while aligned and staying aligned; a restart in CONFIRM
      // presents at the newly chosen offset.
      present_s = rx_raw_valid_i && (state_q != ST_SEARCH) && (state_d != ST_SEARCH);
      dec_en_d  = present_s;
      sym_d     = present_s ? cand_s[align_d] : sym_q;
      // Falling back to SEARCH drops any decoder result still in flight.
      dec_vld_d = (state_d == ST_SEARCH) ? 1'b0 : dec_en_q;
      lock_d    = (state_d == ST_LOCKED);
   end

   // Registered state with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_SEARCH;
         prev_q      <= 10'd0;
         rd_q        <= 1'b0;
         align_q     <= 4'd0;
         comma_cnt_q <= 4'd0;
         err_cnt_q   <= 4'd0;
         good_cnt_q  <= 8'd0;
         dec_vld_q   <= 1'b0;
         dec_en_q    <= 1'b0;
         sym_q       <= 10'd0;
         lock_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_q      <= rx_raw_valid_i ? rx_raw_i : prev_q;
         rd_q        <= rd_d;
         align_q     <= align_d;
         comma_cnt_q <= comma_cnt_d;
         err_cnt_q   <= err_cnt_d;
         good_cnt_q  <= good_cnt_d;
         dec_vld_q   <= dec_vld_d;
         dec_en_q    <= dec_en_d;
         sym_q       <= sym_d;
         lock_q      <= lock_d;
      end
   end

`ifdef RX_LOCK_ERR_STATS_EN
   logic [7:0] stat_q, stat_d;

   // Lifetime decode-error counter, saturating, survives loss of lock.
   always_comb begin
      if (dec_vld_q && dec_err_i && (state_q != ST_SEARCH) && (stat_q != 8'hFF)) begin
         stat_d = stat_q + 8'd1;
      end else begin
         stat_d = stat_q;
      end
   end

   // Error statistics register, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_q <= 8'd0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign err_count_o = stat_q;
`else
   assign err_count_o = 8'd0;
`endif

   assign sym_out_o     = sym_q;
   assign dec_en_o      = dec_en_q;
   assign lock_o        = lock_q;
   assign align_off_o   = align_q;
   assign dec_rd_prev_o = dec_vld_q ? dec_rd_next_i : rd_q;

endmodule

// File: tb/tb_rx_symbol_lock_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for rx_symbol_lock_ctrl: a K28.5 bit stream with selectable slip
// feeds the DUT while a cycle-level reference model, written from the lock
// rules with plain integer arithmetic, predicts every output.
// -----------------------------------------------------------------------------
module tb_rx_symbol_lock_ctrl;

   localparam int LOCK_N  = 4;
   localparam int ERR_LIM = 4;
   localparam int GOOD_N  = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] rx_raw;
   logic       rx_raw_valid;
   logic       dec_err;
   logic       dec_rd_next;
   logic [9:0] sym_out;
   logic       dec_en;
   logic       dec_rd_prev;
   logic       lock;
   logic [3:0] align_off;
   logic [7:0] err_count;

   always #5 clk = ~clk;

   rx_symbol_lock_ctrl #(
      .COMMA_LOCK_CNT(LOCK_N),
      .ERR_LIMIT     (ERR_LIM),
      .GOOD_RUN      (GOOD_N)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_raw_i      (rx_raw),
      .rx_raw_valid_i(rx_raw_valid),
      .dec_err_i     (dec_err),
      .dec_rd_next_i (dec_rd_next),
      .sym_out_o     (sym_out),
      .dec_en_o      (dec_en),
      .dec_rd_prev_o (dec_rd_prev),
      .lock_o        (lock),
      .align_off_o   (align_off),
      .err_count_o   (err_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: 0 = search, 1 = confirm, 2 = locked.
   int m_state, m_prev, m_align, m_cc, m_ec, m_gc, m_rd;
   int m_en, m_vld, m_sym, m_lock, m_stat;
   int spos;
   int sampled_errs;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Word of the serial K28.5 stream (RD-, RD+, ...) starting at bit p.
   function automatic logic [9:0] stream_word(input int p);
      logic [9:0] sym_a, sym_b, s, w;
      sym_a = 10'b0011111010;
      sym_b = 10'b1100000101;
      w = 10'd0;
      for (int i = 0; i < 10; i++) begin
         int pos = p + i;
         s = (((pos / 10) % 2) == 0) ? sym_a : sym_b;
         w[9-i] = s[9-(pos % 10)];
      end
      return w;
   endfunction

   function automatic int cand(input int w20, input int k);
      return (w20 >> (10 - k)) & 1023;
   endfunction

   function automatic int comma_at(input int w20, input int k);
      int h;
      h = cand(w20, k) >> 3;
      return ((h == 31) || (h == 96)) ? 1 : 0;
   endfunction

   task automatic m_reset();
      m_state = 0; m_prev = 0; m_align = 0; m_cc = 0; m_ec = 0; m_gc = 0;
      m_rd = 0; m_en = 0; m_vld = 0; m_sym = 0; m_lock = 0; m_stat = 0;
   endtask

   // One clock edge of the reference model.
   task automatic m_step(input int raw, input int valid, input int err, input int rdn);
      int w20, fk, nst, nal, res, en_new;
      res = m_vld;
      w20 = (m_prev << 10) | raw;
      fk = -1;
      for (int k = 0; k < 10; k++) begin
         if (fk < 0 && comma_at(w20, k) == 1) fk = k;
      end
      nst = m_state;
      nal = m_align;
      if (res == 1) m_rd = rdn;
      if (res == 1 && err == 1 && m_state != 0) begin
         sampled_errs++;
`ifdef RX_LOCK_ERR_STATS_EN
         if (m_stat < 255) m_stat++;
`endif
      end
      case (m_state)
         0: if (valid == 1 && fk >= 0) begin
               nal = fk; m_cc = 1; m_rd = (cand(w20, fk) >> 9) & 1;
               nst = (LOCK_N == 1) ? 2 : 1;
            end
         1: if (res == 1 && err == 1) nst = 0;
            else if (valid == 1) begin
               if (comma_at(w20, m_align) == 1) begin
                  m_cc++;
                  if (m_cc == LOCK_N) nst = 2;
               end else if (fk >= 0) begin
                  nal = fk; m_cc = 1;
               end
            end
         default: if (res == 1) begin
               if (err == 1) begin
                  m_ec = (m_ec + 1 > ERR_LIM) ? ERR_LIM : m_ec + 1;
                  m_gc = 0;
               end else begin
                  m_gc++;
                  if (m_gc == GOOD_N) begin
                     m_gc = 0;
                     if (m_ec > 0) m_ec--;
                  end
               end
               if (m_ec == ERR_LIM) begin nst = 0; m_ec = 0; m_gc = 0; end
            end
      endcase
      en_new = 0;
      if (valid == 1 && m_state != 0 && nst != 0) begin
         en_new = 1;
         m_sym  = cand(w20, nal);
      end
      m_vld = (nst == 0) ? 0 : m_en;
      m_en  = en_new;
      if (valid == 1) m_prev = raw;
      m_state = nst;
      m_align = nal;
      m_lock  = (nst == 2) ? 1 : 0;
   endtask

   task automatic check_outputs();
      chk("sym_out",   32'(sym_out),   32'(m_sym));
      chk("dec_en",    32'(dec_en),    32'(m_en));
      chk("lock",      32'(lock),      32'(m_lock));
      chk("align_off", 32'(align_off), 32'(m_align));
      chk("err_count", 32'(err_count), 32'(m_stat));
   endtask

   // Drive one cycle (starts 1 time unit after a rising edge).
   task automatic tick(input logic [9:0] raw, input logic v, input logic e, input logic rdn);
      rx_raw = raw; rx_raw_valid = v; dec_err = e; dec_rd_next = rdn;
      #1;
      chk("dec_rd_prev", 32'(dec_rd_prev), 32'((m_vld == 1) ? int'(rdn) : m_rd));
      @(posedge clk);
      m_step(int'(raw), int'(v), int'(e), int'(rdn));
      #1;
      check_outputs();
   endtask

   task automatic tick_word(input logic v, input logic e);
      logic [9:0] raw;
      if (v) begin
         raw = stream_word(spos);
         spos += 10;
      end else begin
         raw = 10'($urandom);
      end
      tick(raw, v, e, 1'($urandom_range(0, 1)));
   endtask

   // Continuous valid words until n decoder results have been given flag e.
   task automatic feed(input int n, input logic e);
      int left = n;
      int guard = 0;
      while (left > 0 && guard < 200) begin
         if (m_vld == 1) begin
            tick_word(1'b1, e);
            left--;
         end else begin
            tick_word(1'b1, 1'b0);
         end
         guard++;
      end
      chk("feed_done", 32'(left), 32'd0);
   endtask

   initial begin
      logic [9:0] pat;
      int nerr, guard;
      logic v, e;

      // Reset
      rst = 1'b0; rx_raw = 10'd0; rx_raw_valid = 1'b0; dec_err = 1'b0; dec_rd_next = 1'b0;
      m_reset(); spos = 7; sampled_errs = 0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      chk("reset_rd_prev", 32'(dec_rd_prev), 32'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;

      // Acquire lock on a 3-bit-slipped K28.5 stream
      for (int i = 0; i < 8; i++) begin
         tick_word(1'b1, 1'b0);
         if (i == 1) chk("A_align_first_comma", 32'(align_off), 32'd3);
         if (i == 3) chk("A_no_lock_3_commas", 32'(lock), 32'd0);
         if (i == 4) chk("A_lock_4th_comma", 32'(lock), 32'd1);
      end

      // Valid gap mid-lock
      for (int i = 0; i < 5; i++) begin
         tick_word(1'b0, 1'b0);
         if (i >= 1) chk("B_gap_dec_en", 32'(dec_en), 32'd0);
         chk("B_gap_lock", 32'(lock), 32'd1);
      end
      for (int i = 0; i < 3; i++) tick_word(1'b1, 1'b0);

      // 3 errors, 16 good, 1 error: lock holds; one more error drops it
      feed(3, 1'b1);
      feed(GOOD_N, 1'b0);
      feed(1, 1'b1);
      chk("C_lock_holds_after_decrement", 32'(lock), 32'd1);
      feed(1, 1'b1);
      chk("C_lock_lost", 32'(lock), 32'd0);
      chk("C_dec_en_off", 32'(dec_en), 32'd0);

      // Relock, then 4 errors scattered within 10 symbols
      for (int i = 0; i < 6; i++) tick_word(1'b1, 1'b0);
      chk("C2_relocked", 32'(lock), 32'd1);
      pat = 10'b1010010010;
      nerr = 0;
      for (int i = 0; i < 10; i++) begin
         feed(1, pat[9-i]);
         if (pat[9-i]) nerr++;
         if (nerr == ERR_LIM) begin
            chk("C2_lock_lost", 32'(lock), 32'd0);
            chk("C2_dec_en_off", 32'(dec_en), 32'd0);
            break;
         end
      end

      // Two commas at offset 3 in CONFIRM, then the boundary moves to 7
      tick_word(1'b1, 1'b0);
      chk("D_align_3", 32'(align_off), 32'd3);
      tick_word(1'b1, 1'b0);
      spos += 6;
      for (int i = 0; i < 5; i++) begin
         tick_word(1'b1, 1'b0);
         if (i == 1) chk("D_align_7", 32'(align_off), 32'd7);
         if (i == 3) chk("D_no_lock_yet", 32'(lock), 32'd0);
         if (i == 4) chk("D_lock_at_7", 32'(lock), 32'd1);
      end

      // Asynchronous reset while in CONFIRM
      feed(ERR_LIM, 1'b1);
      tick_word(1'b1, 1'b0);
      tick_word(1'b1, 1'b0);
      chk("E_presenting_before_reset", 32'(dec_en), 32'd1);
      rx_raw_valid = 1'b0; dec_err = 1'b0;
      #3;
      rst = 1'b0;
      #1;
      chk("E_async_sym",     32'(sym_out),     32'd0);
      chk("E_async_dec_en",  32'(dec_en),      32'd0);
      chk("E_async_lock",    32'(lock),        32'd0);
      chk("E_async_align",   32'(align_off),   32'd0);
      chk("E_async_errcnt",  32'(err_count),   32'd0);
      chk("E_async_rd_prev", 32'(dec_rd_prev), 32'd0);
      m_reset();
      @(negedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;

      // Randomised traffic with gaps, slips and heavy error injection
      sampled_errs = 0;
      guard = 0;
      while (sampled_errs < 300 && guard < 6000) begin
         v = ($urandom_range(0, 7) != 0);
         if (m_vld == 1) e = ($urandom_range(0, 2) == 0);
         else            e = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 63) == 0) spos += $urandom_range(1, 9);
         tick_word(v, e);
         guard++;
      end
      chk("F_error_budget", 32'((sampled_errs >= 300) ? 1 : 0), 32'd1);
`ifdef RX_LOCK_ERR_STATS_EN
      chk("F_err_count_saturated", 32'(err_count), 32'd255);
`else
      chk("F_err_count_tied", 32'(err_count), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
